// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: single-cycle ALU ops plus a bit-serial shifter
// that stalls the input for one cycle per shift position.
module ex_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_op,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            rf_write_en,
    output logic [4:0]      rf_write_reg,
    output logic [XLEN-1:0] rf_write_data,
    output logic            illegal
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_e;

    state_e          state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [XLEN-1:0] shift_val_q, shift_val_d;
    shift_kind_e     kind_q, kind_d;
    logic [4:0]      shift_rd_q, shift_rd_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_reg_q, rf_reg_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] shift_step;
    logic            accept;
    logic            op_is_shift;
    logic            op_illegal;
    shift_kind_e     in_kind;

    assign in_ready   = (state_q == IDLE) && !flush;
    assign accept     = in_valid && in_ready;
    assign op_a       = in_rs1_data;
    assign op_b       = in_use_imm ? in_imm : in_rs2_data;
    assign shamt      = op_b[4:0];
    assign op_illegal = (in_alu_op > 4'd9);

    // Single-cycle ALU; shift ops only reach writeback from here when s == 0.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_result  = '0;
        op_is_shift = 1'b0;
        in_kind     = SK_SLL;
        case (alu_op_e'(in_alu_op))
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_SLL: begin
                alu_result  = op_a;
                op_is_shift = 1'b1;
                in_kind     = SK_SLL;
            end
            OP_SRL: begin
                alu_result  = op_a;
                op_is_shift = 1'b1;
                in_kind     = SK_SRL;
            end
            OP_SRA: begin
                alu_result  = op_a;
                op_is_shift = 1'b1;
                in_kind     = SK_SRA;
            end
            default: alu_result = '0;
        endcase
    end

    // One shift position per cycle; SRA keeps bit 31, so the original sign is preserved.
    always_comb begin
        shift_step = shift_val_q;
        case (kind_q)
            SK_SLL:  shift_step = {shift_val_q[XLEN-2:0], 1'b0};
            SK_SRL:  shift_step = {1'b0, shift_val_q[XLEN-1:1]};
            SK_SRA:  shift_step = {shift_val_q[XLEN-1], shift_val_q[XLEN-1:1]};
            default: shift_step = shift_val_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_val_d = shift_val_q;
        kind_d      = kind_q;
        shift_rd_d  = shift_rd_q;
        rf_we_d     = 1'b0;
        rf_reg_d    = rf_reg_q;
        rf_data_d   = rf_data_q;
        illegal_d   = 1'b0;

        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_illegal) begin
                            illegal_d = 1'b1;
                        end else if (op_is_shift && (shamt != 5'd0)) begin
                            state_d     = SHIFT;
                            count_d     = shamt;
                            shift_val_d = op_a;
                            kind_d      = in_kind;
                            shift_rd_d  = in_rd;
                        end else if (in_rd != 5'd0) begin
                            rf_we_d   = 1'b1;
                            rf_reg_d  = in_rd;
                            rf_data_d = alu_result;
                        end
                    end
                end
                SHIFT: begin
                    shift_val_d = shift_step;
                    count_d     = count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        state_d = IDLE;
                        if (shift_rd_q != 5'd0) begin
                            rf_we_d   = 1'b1;
                            rf_reg_d  = shift_rd_q;
                            rf_data_d = shift_step;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shift_val_q <= '0;
            kind_q      <= SK_SLL;
            shift_rd_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_reg_q    <= '0;
            rf_data_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_val_q <= shift_val_d;
            kind_q      <= kind_d;
            shift_rd_q  <= shift_rd_d;
            rf_we_q     <= rf_we_d;
            rf_reg_q    <= rf_reg_d;
            rf_data_q   <= rf_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign rf_write_en   = rf_we_q;
    assign rf_write_reg  = rf_reg_q;
    assign rf_write_data = rf_data_q;
    assign illegal       = illegal_q;

endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width (only 32 supported).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset (rst=0 resets).
REQ-004 SHALL have port in_valid  input  1  decoded instruction present.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have port in_rs1_data  input  32  operand A from regfile.
REQ-007 SHALL have port in_rs2_data  input  32  operand B from regfile.
REQ-008 SHALL have port in_imm  input  32  sign-extended immediate.
REQ-009 SHALL have port in_use_imm  input  1  1: operand B = in_imm (I-type).
REQ-010 SHALL have port in_alu_op  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
REQ-011 SHALL have port in_rd  input  5  destination register.
REQ-012 SHALL have port flush  input  1  synchronous kill of in-flight op.
REQ-013 SHALL have port rf_write_en  output  1  regfile write strobe.
REQ-014 SHALL have port rf_write_reg  output  5  regfile write address.
REQ-015 SHALL have port rf_write_data  output  32  regfile write data.
REQ-016 SHALL have port illegal  output  1  one-cycle pulse for unsupported alu_op.

Function
REQ-017 SHALL implement FSM states IDLE and SHIFT; accept = in_valid & in_ready.
REQ-018 SHALL drive in_ready = 1 in IDLE and flush = 0; 0 in SHIFT or when flush = 1.
REQ-019 SHALL select B = in_use_imm ? in_imm : in_rs2_data; shift amount s = B[4:0].
REQ-020 SHALL, for non-shift ops on accept at edge E0, register result, rd and rf_write_en = (rd != 0) at E0; throughput one op per cycle.
REQ-021 SHALL compute ADD/SUB modulo 2^32, SLT signed, SLTU unsigned, results 0/1 zero-extended.
REQ-022 SHALL perform shifts iteratively one bit per cycle: s = 0 behaves as REQ-020; s > 0 loads count = s at E0, enters SHIFT, shifts once per edge E1..Es, writes back at Es, returns to IDLE at Es.
REQ-023 SHALL fill SRL with 0, SRA with original bit 31, SLL with 0 at bit 0.
REQ-024 SHALL hold rf_write_en high exactly one cycle per writeback; 0 in all other cycles including SHIFT cycles.
REQ-025 SHALL never assert rf_write_en for rd = 0; the op otherwise completes with identical timing.
REQ-026 SHALL, for alu_op 10-15, pulse illegal one cycle after E0, keep rf_write_en 0, remain in IDLE.
REQ-027 SHALL, on flush = 1 at an edge, abort SHIFT to IDLE, force rf_write_en 0 for that edge, discard the count; flush wins over simultaneous in_valid.
REQ-028 SHALL hold rf_write_reg/rf_write_data at last written values while rf_write_en = 0.

Reset
REQ-029 SHALL, while rst = 0 (asynchronous), force IDLE, count 0, rf_write_en 0, rf_write_reg 0, rf_write_data 0, illegal 0; in_ready = 1 after release.
REQ-030 SHALL abandon any in-flight shift when reset asserts mid-operation, with no writeback after release.

Verification
REQ-031 SHALL test: rs1=10, rs2=15, ADD, rd=3 -> rf_write_en=1, reg 3, data 25 one cycle after accept.
REQ-032 SHALL test: back-to-back XOR(0xF0,0xFF,rd=1), SUB(5,7,rd=2) -> consecutive writes 0x0F then 0xFFFFFFFE.
REQ-033 SHALL test: SRA rs1=0x80000000, imm=4, rd=5 -> in_ready low 4 cycles, write 0xF8000000 at E4; s=0 SLL -> write next cycle.
REQ-034 SHALL test: ADDI rd=0 -> rf_write_en stays 0; alu_op=12 -> illegal one-cycle pulse, no write.
REQ-035 SHALL test: flush at E2 of SLL by 8 -> no write, in_ready high next cycle; rst=0 at E3 of an SRL by 6 -> outputs 0 immediately, no write after release.
